add_rr_sched: RTL and testbench

- Time-shares one fully pipelined unsigned adder (16+16→17 bit, fixed latency) among NUM_REQ requesters.
- Arbitration is round-robin. The block registers operands toward the adder and tracks in-flight tags in a shift register matched to the adder latency.
- Results return through a credit-protected output FIFO on a single tagged valid/ready result bus.
- Sits between the channelizer's producer stages and the shared adder instance.

---
 rtl/add_rr_sched_pkg.sv | 29 ++
 rtl/add_rr_sched_rr_arbiter.sv | 39 +++
 rtl/add_rr_sched.sv | 203 ++++++++++++++++++++
 tb/tb_add_rr_sched.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_rr_sched_pkg.sv
// add_sched_pkg: shared constants, width helpers and the result FIFO entry
// layout for the add_rr_sched block.
//   DEF_DATA_WIDTH / DEF_ADD_LAT : default operand width and adder latency
//   res_w()                      : adder result width (operand width + carry)
//   clog2()                      : ceiling log2 for elaboration-time sizing
//   fifo_entry_t                 : {tag, data} entry for the default build
package add_sched_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADD_LAT    = 2;
  localparam int unsigned MAX_TAG_W      = 3;

  function automatic int unsigned res_w(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

  typedef struct packed {
    logic [MAX_TAG_W-1:0]      tag;
    logic [DEF_DATA_WIDTH:0]   data;
  } fifo_entry_t;

endpackage

// File: rtl/add_rr_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
// Scans rr_ptr+1 .. rr_ptr+NUM_REQ (mod NUM_REQ) and grants the first
// requester with req set, but only while credit_ok is high.
//   rr_ptr    in   index of the most recently granted requester
//   req       in   per-requester request
//   credit_ok in   a result slot is available downstream
//   grant     out  one-hot grant (all zero when nothing is granted)
//   grant_idx out  index of the granted requester
//   grant_any out  a grant was made this cycle
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [IDX_W-1:0]   rr_ptr,
  input  logic [NUM_REQ-1:0] req,
  input  logic               credit_ok,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (credit_ok && !grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/add_rr_sched.sv
// add_rr_sched: time-shares one pipelined adder among NUM_REQ requesters.
// Round-robin grant, registered operand issue, a tag pipe matched to the
// adder latency, and a credit-protected first-word-fall-through result FIFO.
// Optional statistics counters are built when ADD_RR_SCHED_STATS_EN is defined.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req_valid / req_ready   per-requester operand handshake (ready one-hot)
//   req_a / req_b           packed operands, requester i at [i*DW +: DW]
//   add_valid_o/add_a/add_b registered issue to the adder
//   add_valid_i / add_c     adder return
//   res_valid/res_ready     tagged result bus (res_tag, res_data)
//   err_o                   sticky adder-return protocol error
//   stat_issue/stat_stall   saturating counters (ADD_RR_SCHED_STATS_EN only)
module add_rr_sched
  import add_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADD_LAT    = DEF_ADD_LAT,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          add_valid_o,
  output logic [DATA_WIDTH-1:0]         add_a,
  output logic [DATA_WIDTH-1:0]         add_b,
  input  logic                          add_valid_i,
  input  logic [res_w(DATA_WIDTH)-1:0]  add_c,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [TAG_W-1:0]              res_tag,
  output logic [res_w(DATA_WIDTH)-1:0]  res_data,
  output logic                          err_o
`ifdef ADD_RR_SCHED_STATS_EN
  ,
  output logic [31:0]                   stat_issue,
  output logic [31:0]                   stat_stall
`endif
);

  localparam int unsigned RES_W = res_w(DATA_WIDTH);
  localparam int unsigned AW    = clog2(FIFO_DEPTH);
  localparam int unsigned CW    = clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [RES_W-1:0] data;
  } entry_t;

  // ---------------- arbitration ----------------
  logic [TAG_W-1:0]      rr_ptr;
  logic [TAG_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  credit_ok;
  logic [CW-1:0]         credits;
  logic                  pop;

  // Reset also masks the combinational grant so req_ready reads 0 while held.
  assign credit_ok = (credits != '0) && !reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (TAG_W)
  ) u_arb (
    .rr_ptr    (rr_ptr),
    .req       (req_valid),
    .credit_ok (credit_ok),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  logic [DATA_WIDTH-1:0] op_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] op_b [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_a[g] = req_a[g*DATA_WIDTH +: DATA_WIDTH];
    assign op_b[g] = req_b[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------- issue ----------------
  logic [TAG_W-1:0] issue_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_valid_o <= 1'b0;
      add_a       <= '0;
      add_b       <= '0;
      issue_tag   <= '0;
      rr_ptr      <= TAG_W'(NUM_REQ - 1);
    end else begin
      add_valid_o <= grant_any;
      if (grant_any) begin
        add_a     <= op_a[grant_idx];
        add_b     <= op_b[grant_idx];
        issue_tag <= grant_idx;
        rr_ptr    <= grant_idx;
      end
    end
  end

  // ---------------- tag pipe ----------------
  // Fed from the issue register, so the tail lines up with add_valid_i.
  logic             pipe_v   [ADD_LAT];
  logic [TAG_W-1:0] pipe_tag [ADD_LAT];
  logic             tail_v;
  logic [TAG_W-1:0] tail_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ADD_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_tag[i] <= '0;
      end
    end else begin
      pipe_v[0]   <= add_valid_o;
      pipe_tag[0] <= issue_tag;
      for (int unsigned i = 1; i < ADD_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  assign tail_v   = pipe_v[ADD_LAT-1];
  assign tail_tag = pipe_tag[ADD_LAT-1];

  // Any disagreement between adder return and expected tail is an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_o <= 1'b0;
    else if (add_valid_i != tail_v) err_o <= 1'b1;
  end

  // ---------------- result FIFO ----------------
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          full;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign push      = add_valid_i && tail_v && !full;
  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{tag: tail_tag, data: add_c};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head is forced to zero when empty so storage needs no reset.
  assign res_tag  = res_valid ? mem[rd_ptr].tag  : '0;
  assign res_data = res_valid ? mem[rd_ptr].data : '0;

  // ---------------- credits ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits <= CW'(FIFO_DEPTH);
    end else begin
      case ({grant_any, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

`ifdef ADD_RR_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else begin
      if (grant_any && (stat_issue != '1))
        stat_issue <= stat_issue + 32'd1;
      if ((|req_valid) && (credits == '0) && (stat_stall != '1))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_add_rr_sched.sv
// Self-checking bench for add_rr_sched with a behavioural adder, a
// round-robin/credit reference model and an in-order result scoreboard.
module tb_add_rr_sched;

  localparam int unsigned NR  = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 2;
  localparam int unsigned FD  = 4;
  localparam int unsigned TW  = 2;
  localparam int unsigned RW  = DW + 1;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic             add_valid_o;
  logic [DW-1:0]    add_a;
  logic [DW-1:0]    add_b;
  logic             add_valid_i;
  logic [RW-1:0]    add_c;
  logic             res_valid;
  logic             res_ready;
  logic [TW-1:0]    res_tag;
  logic [RW-1:0]    res_data;
  logic             err_o;
`ifdef ADD_RR_SCHED_STATS_EN
  logic [31:0]      stat_issue;
  logic [31:0]      stat_stall;
`endif

  logic [DW-1:0] op_a [NR];
  logic [DW-1:0] op_b [NR];
  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  add_rr_sched #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .ADD_LAT    (LAT),
    .FIFO_DEPTH (FD),
    .TAG_W      (TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .add_valid_o (add_valid_o),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_valid_i (add_valid_i),
    .add_c       (add_c),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_tag     (res_tag),
    .res_data    (res_data),
    .err_o       (err_o)
`ifdef ADD_RR_SCHED_STATS_EN
    ,
    .stat_issue  (stat_issue),
    .stat_stall  (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder sharing the block's reset; inject forces a stray valid.
  logic          av [LAT];
  logic [RW-1:0] ad [LAT];
  logic          inject;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        av[i] <= 1'b0;
        ad[i] <= '0;
      end
    end else begin
      av[0] <= add_valid_o;
      ad[0] <= RW'(add_a) + RW'(add_b);
      for (int i = 1; i < LAT; i++) begin
        av[i] <= av[i-1];
        ad[i] <= ad[i-1];
      end
    end
  end

  assign add_valid_i = av[LAT-1] | inject;
  assign add_c       = ad[LAT-1];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      op_a[i] = 16'($urandom);
      op_b[i] = 16'($urandom);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_add_valid_o", 32'(add_valid_o), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_tag", 32'(res_tag), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_err_o", 32'(err_o), 32'd0);
  endtask

  // ---------------- reference model + scoreboard monitor ----------------
  typedef struct {
    int            tag;
    logic [RW-1:0] data;
    int            rdy;
  } exp_t;

  exp_t          sb [$];
  int            cyc      = 0;
  int            credits_m = FD;
  int            last_g   = NR - 1;
  logic          prev_hs  = 1'b0;
  logic [DW-1:0] prev_a   = '0;
  logic [DW-1:0] prev_b   = '0;
  logic          exp_err  = 1'b0;
  int            eg;
  int            cand;
  logic [NR-1:0] exp_rdy;
  logic          exp_vis;
  exp_t          e;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        sb.delete();
        credits_m = FD;
        last_g    = NR - 1;
        prev_hs   = 1'b0;
      end else begin
        eg = -1;
        if (credits_m > 0) begin
          for (int k = 1; k <= NR; k++) begin
            cand = (last_g + k) % NR;
            if (eg < 0 && req_valid[cand[TW-1:0]]) eg = cand;
          end
        end
        exp_rdy = (eg >= 0) ? (NR'(1) << eg) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("add_valid_o", 32'(add_valid_o), 32'(prev_hs));
        if (prev_hs) begin
          check("add_a", 32'(add_a), 32'(prev_a));
          check("add_b", 32'(add_b), 32'(prev_b));
        end
        check("err_o", 32'(err_o), 32'(exp_err));
        exp_vis = (sb.size() > 0) && (sb[0].rdy <= cyc);
        check("res_valid", 32'(res_valid), 32'(exp_vis));
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            check("res_valid_unexpected", 32'(res_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            check("res_tag", 32'(res_tag), 32'(e.tag));
            check("res_data", 32'(res_data), 32'(e.data));
            credits_m++;
          end
        end
        if (eg >= 0) begin
          sb.push_back('{tag: eg,
                         data: RW'(op_a[eg[TW-1:0]]) + RW'(op_b[eg[TW-1:0]]),
                         rdy: cyc + 4});
          credits_m--;
          last_g = eg;
          prev_a = op_a[eg[TW-1:0]];
          prev_b = op_b[eg[TW-1:0]];
        end
        prev_hs = (eg >= 0);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  int n;

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    inject    = 1'b0;
    exp_err   = 1'b0;
    for (int i = 0; i < NR; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    #3;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    // single request: 5 + 3 from requester 0
    res_ready = 1'b1;
    step();
    op_a[0] = 16'h0005; op_b[0] = 16'h0003; req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (8) step();

    // carry out of the top bit from requester 2
    op_a[2] = 16'hFFFF; op_b[2] = 16'hFFFF; req_valid = 4'b0100;
    step();
    req_valid = '0;
    repeat (8) step();

    // fairness: all requesting for 8 cycles
    for (int c = 0; c < 8; c++) begin
      rand_ops();
      req_valid = 4'b1111;
      step();
    end
    req_valid = '0;
    repeat (8) step();

    // backpressure: credits run out after FIFO_DEPTH handshakes
    res_ready = 1'b0;
    req_valid = 4'b1111;
    rand_ops();
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) n++;
    end
    check("bp_handshakes", 32'(n), 32'd4);
    step();
    res_ready = 1'b1;
    n = 0;
    @(negedge clk);
    if (|(req_ready & req_valid)) n++;
    step();
    res_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) n++;
    end
    check("bp_one_more", 32'(n), 32'd1);
    step();
    req_valid = '0;
    res_ready = 1'b1;
    repeat (10) step();

    // random traffic
    repeat (300) begin
      rand_ops();
      req_valid = 4'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (12) step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    // stray adder valid with nothing in flight
    inject = 1'b1;
    step();
    inject  = 1'b0;
    exp_err = 1'b1;
    repeat (6) step();

    // reset with two operations in flight
    rand_ops();
    req_valid = 4'b0011;
    step();
    step();
    req_valid = '0;
    #2;
    reset   = 1'b1;
    exp_err = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk);
    #3 reset = 1'b0;

    // full credit count after reset
    step();
    res_ready = 1'b0;
    req_valid = 4'b1111;
    rand_ops();
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) n++;
    end
    check("post_reset_credits", 32'(n), 32'd4);
    step();
    req_valid = '0;
    res_ready = 1'b1;
    repeat (10) step();

    // a fresh single request completes normally
    op_a[3] = 16'h1234; op_b[3] = 16'h4321; req_valid = 4'b1000;
    step();
    req_valid = '0;
    repeat (8) step();
    check("sb_drained_end", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
